// File: rtl/sort_cmp_ctrl.sv
// Purpose : sequential bubble sort of N words, one compare/swap per clock through a shared external comparator.
// Latency : done = C+1 cycles after the start edge, C = compare cycles (N-1 .. N*(N-1)/2).
// Backpressure: none; start is honoured only in IDLE, never queued.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, din         sort request and N unsorted words (word i at din[i*WIDTH +: WIDTH])
//   cmp_a/cmp_b        operands driven to the external comparator (zero outside CMP)
//   cmp_l/cmp_e/cmp_g  comparator result, sampled in the same cycle
//   busy, done, dout   sort in progress, one-cycle valid pulse, sorted words (held until next FIN)
//   swap_count         swaps performed in the last/current sort
//   cmp_err            sticky flag: comparator result was not one-hot during CMP
//
// Build option: define SORT_CMP_DESC_EN for descending order (swap on cmp_l instead of cmp_g).
module sort_cmp_ctrl #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   din,
    output logic [WIDTH-1:0]     cmp_a,
    output logic [WIDTH-1:0]     cmp_b,
    input  logic                 cmp_l,
    input  logic                 cmp_e,
    input  logic                 cmp_g,
    output logic                 busy,
    output logic                 done,
    output logic [N*WIDTH-1:0]   dout,
    output logic [CNT_W-1:0]     swap_count,
    output logic                 cmp_err
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r [N];
    logic [IDX_W-1:0] idx, pass;
    logic             swapped;

    logic [WIDTH-1:0] a_w, b_w;
    logic             swap_c;
    logic             do_swap, pass_end, sort_end;

    assign a_w = r[idx];
    assign b_w = r[idx + IDX_W'(1)];

`ifdef SORT_CMP_DESC_EN
    assign swap_c = cmp_l;
`else
    assign swap_c = cmp_g;
`endif

    always_comb begin
        state_nxt = state;
        cmp_a     = '0;
        cmp_b     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        do_swap   = 1'b0;
        pass_end  = 1'b0;
        sort_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CMP;
            end
            CMP: begin
                busy     = 1'b1;
                cmp_a    = a_w;
                cmp_b    = b_w;
                do_swap  = swap_c;
                // Each pass leaves its largest element in place, so the pass shrinks by one.
                pass_end = (idx == LAST_PASS - pass);
                // Early exit: a pass without any swap (this cycle included) means sorted.
                sort_end = pass_end && (!(swapped || do_swap) || (pass == LAST_PASS));
                if (sort_end) state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            cmp_err    <= 1'b0;
            dout       <= '0;
            for (int i = 0; i < N; i++) r[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) r[i] <= din[i*WIDTH +: WIDTH];
                        swap_count <= '0;
                        idx        <= '0;
                        pass       <= '0;
                        swapped    <= 1'b0;
                    end
                end
                CMP: begin
                    if (!$onehot({cmp_l, cmp_e, cmp_g})) cmp_err <= 1'b1;
                    if (do_swap) begin
                        r[idx]              <= b_w;
                        r[idx + IDX_W'(1)]  <= a_w;
                        swapped             <= 1'b1;
                        if (swap_count != '1) swap_count <= swap_count + CNT_W'(1);
                    end
                    if (sort_end) begin
                        // Capture the final vector including this cycle's swap so dout
                        // is already valid while done is high in FIN.
                        for (int i = 0; i < N; i++) begin
                            if (do_swap && (IDX_W'(i) == idx))
                                dout[i*WIDTH +: WIDTH] <= b_w;
                            else if (do_swap && (IDX_W'(i) == idx + IDX_W'(1)))
                                dout[i*WIDTH +: WIDTH] <= a_w;
                            else
                                dout[i*WIDTH +: WIDTH] <= r[i];
                        end
                    end else if (pass_end) begin
                        pass    <= pass + IDX_W'(1);
                        idx     <= '0;
                        swapped <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_cmp_ctrl.sv
module tb_sort_cmp_ctrl;

    localparam int WIDTH = 3;
    localparam int N     = 4;
    localparam int CNT_W = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [N*WIDTH-1:0]   din;
    logic [WIDTH-1:0]     cmp_a, cmp_b;
    logic                 cmp_l, cmp_e, cmp_g;
    logic                 busy, done;
    logic [N*WIDTH-1:0]   dout;
    logic [CNT_W-1:0]     swap_count;
    logic                 cmp_err;

    logic force_l = 1'b0;
    logic force_g = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Reference 3-bit magnitude comparator, with a hook to corrupt its result.
    assign cmp_l = force_l | (cmp_a < cmp_b);
    assign cmp_e = (cmp_a == cmp_b) & ~force_l & ~force_g;
    assign cmp_g = force_g | (cmp_a > cmp_b);

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    sort_cmp_ctrl #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_l      (cmp_l),
        .cmp_e      (cmp_e),
        .cmp_g      (cmp_g),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .swap_count (swap_count),
        .cmp_err    (cmp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // word 0 = w0 in the low bits
    function automatic logic [N*WIDTH-1:0] pack(input int w0, input int w1, input int w2, input int w3);
        return {WIDTH'(w3), WIDTH'(w2), WIDTH'(w1), WIDTH'(w0)};
    endfunction

    // Runs one sort and checks result, swap count, latency and single done pulse.
    // xstart_cyc / err_cyc: cycle (1 = first after start edge) in which to pulse
    // start again or corrupt the comparator; 0 = never.
    task automatic run_sort(input string tag, input logic [N*WIDTH-1:0] d,
                            input logic [N*WIDTH-1:0] exp_d, input int exp_sw,
                            input int exp_lat, input int xstart_cyc, input int err_cyc);
        int cyc;
        int d0;
        bit seen;
        @(posedge clk); #1;
        din   = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0    = done_cnt;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            force_l = (cyc == err_cyc);
            force_g = (cyc == err_cyc);
            start   = (cyc == xstart_cyc);
            if (done) begin
                seen = 1'b1;
                check({tag, "_lat"},  32'(cyc), 32'(exp_lat));
                check({tag, "_dout"}, 32'(dout), 32'(exp_d));
                check({tag, "_swaps"}, 32'(swap_count), 32'(exp_sw));
                check({tag, "_busy_fin"}, 32'(busy), 32'd1);
            end
        end
        force_l = 1'b0;
        force_g = 1'b0;
        start   = 1'b0;
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_cmp"}, 32'({cmp_a, cmp_b}), 32'd0);
        repeat (5) @(negedge clk);
        check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_dout_hold"}, 32'(dout), 32'(exp_d));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_dout",  32'(dout), 32'd0);
        check("rst_swaps", 32'(swap_count), 32'd0);
        check("rst_err",   32'(cmp_err), 32'd0);
        check("rst_cmp",   32'({cmp_a, cmp_b}), 32'd0);

`ifdef SORT_CMP_DESC_EN
        run_sort("d0123", pack(0,1,2,3), pack(3,2,1,0), 6, 7, 0, 0);
        run_sort("d3210", pack(3,2,1,0), pack(3,2,1,0), 0, 4, 0, 0);
        run_sort("d3120", pack(3,1,2,0), pack(3,2,1,0), 1, 6, 0, 0);
        run_sort("d5555", pack(5,5,5,5), pack(5,5,5,5), 0, 4, 0, 0);
        check("d_err", 32'(cmp_err), 32'd0);
`else
        run_sort("s3120", pack(3,1,2,0), pack(0,1,2,3), 5, 7, 0, 0);
        check("s3120_err", 32'(cmp_err), 32'd0);
        run_sort("s0123", pack(0,1,2,3), pack(0,1,2,3), 0, 4, 0, 0);
        run_sort("s5555", pack(5,5,5,5), pack(5,5,5,5), 0, 4, 0, 0);
        run_sort("s7654", pack(7,6,5,4), pack(4,5,6,7), 6, 7, 0, 0);

        // Abort a sort with reset at compare cycle 2.
        @(posedge clk); #1;
        din   = pack(7,6,5,4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        d0    = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_dout",  32'(dout), 32'd0);
        check("abort_swaps", 32'(swap_count), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_sort("s2013", pack(2,0,1,3), pack(0,1,2,3), 2, 6, 0, 0);

        // Second start while busy ignored; comparator corrupted in cycle 2.
        run_sort("sbusy", pack(3,1,2,0), pack(0,1,2,3), 5, 7, 3, 2);
        check("err_set", 32'(cmp_err), 32'd1);
        run_sort("s1032", pack(1,0,3,2), pack(0,1,2,3), 2, 6, 0, 0);
        check("err_sticky", 32'(cmp_err), 32'd1);
`endif

        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("err_clr", 32'(cmp_err), 32'd0);
        check("end_dout", 32'(dout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
